sat_accumulator: RTL
====================

SAT_ACCUMULATOR -- requirements
Module: sat_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 16, lane width in bits, signed two's complement, legal range 2..64.
REQ-002 SHALL have parameter LANES, default 4, number of independent accumulator lanes, legal range 1..16.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  input beat offered.
REQ-006 SHALL have port in_ready  output  1  block accepts the input beat this cycle.
REQ-007 SHALL have port in_op  input  2  operation code: 00 add, 01 subtract, 10 load, 11 clear.
REQ-008 SHALL have port in_data  input  LANES*WIDTH  operand; lane i occupies bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port out_valid  output  1  out_data holds a result not yet taken.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-011 SHALL have port out_data  output  LANES*WIDTH  accumulator values, with the same lane packing as in_data.
REQ-012 SHALL have port sat_flags  output  LANES  sticky per-lane saturation flags.
REQ-013 SHALL have port flag_clr  input  1  clears sat_flags.

Function
REQ-014 Input transfer SHALL occur when in_valid and in_ready are both 1; output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-015 in_ready SHALL equal (!out_valid || out_ready), combinationally, with one result slot and no bubble under full throughput.
REQ-016 On input transfer, each lane's acc[i] SHALL update on that edge, and out_valid SHALL be 1 from the next cycle; latency is 1 clock.
REQ-017 out_valid SHALL clear after an output transfer with no simultaneous input transfer; with a simultaneous input transfer it SHALL remain 1 and carry the new result.
REQ-018 out_data SHALL be the acc registers directly and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-019 Add: the lane SHALL compute acc+d in WIDTH+1 bits and clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-020 Subtract: the lane SHALL compute acc-d in WIDTH+1 bits and apply the same clamp; acc=0, d=min SHALL give max.
REQ-021 Load: acc SHALL become d, with no saturation event; Clear: acc SHALL become 0, with in_data ignored.
REQ-022 Saturation event for a lane SHALL mean the clamp changed the value on an add or subtract transfer.
REQ-023 Lanes SHALL be fully independent; saturation in one lane SHALL NOT affect the others.
REQ-024 With no input transfer, acc SHALL hold its value.

Reset
REQ-025 rst_n low SHALL immediately force acc[all]=0, out_valid=0, and sat_flags=0, regardless of the clock.
REQ-026 in_ready SHALL read 1 during and after reset, following REQ-015.
REQ-027 Reset asserted mid-operation SHALL discard any pending result; the first transfer after reset release SHALL operate on acc=0.

Configuration
REQ-028 Macro SAT_ACCUMULATOR_STICKY_FLAGS_EN SHALL control the sticky flags.
REQ-029 With the macro defined: on a saturation event, sat_flags[i] SHALL set on that edge and hold until flag_clr=1 samples high; a set event in the same cycle as flag_clr SHALL win, and the flag SHALL read 1.
REQ-030 With the macro undefined: sat_flags SHALL be constant 0, flag_clr SHALL be ignored, no flag registers SHALL exist, and all other behaviour SHALL be unchanged.

Verification (WIDTH=16, LANES=4, macro defined unless stated)
REQ-031 Load lane0=0x7FF0, then add 0x0020 -> out_data lane0=0x7FFF, sat_flags=4'b0001, other lanes unchanged.
REQ-032 Load lane1=0x8005, then subtract 0x0010 -> lane1=0x8000, sat_flags[1]=1; then add 0x0001 -> lane1=0x8001, flag still 1.
REQ-033 Load 0x1234 in all lanes, then add 0xFFFF -> all lanes 0x1233, sat_flags=0, out_valid exactly 1 cycle after accept.
REQ-034 Hold out_ready=0 and offer two beats -> first beat accepted, in_ready=0 and second beat held until out_ready=1; no result lost, with 1 transfer per cycle thereafter.
REQ-035 Set flag_clr=1 on the same edge as a lane2 saturating add -> sat_flags[2]=1; then flag_clr=1 alone -> 0. With the macro undefined, sat_flags=0 throughout.
REQ-036 Pull rst_n low mid-cycle while out_valid=1 and out_ready=0 -> out_valid, out_data, and sat_flags read 0 before the next edge; after release, add 0x0005 -> 0x0005.

Source files
------------

// File: rtl/sat_accumulator.sv
// -----------------------------------------------------------------------------
// sat_accumulator
//
// Purpose:
//   LANES independent signed accumulators of WIDTH bits each. Every accepted
//   input beat applies one operation (add, subtract, load, clear) to all lanes
//   at once. Add and subtract saturate to the signed range of a lane. The
//   accumulator registers are presented directly on out_data through a
//   single-entry result slot.
//
// Optional feature:
//   SAT_ACCUMULATOR_STICKY_FLAGS_EN
//     defined   : per-lane sticky saturation flags. A flag sets when its lane
//                 clamps on an add or subtract. flag_clr clears the flags. A
//                 set in the same cycle as flag_clr takes priority.
//     undefined : sat_flags is tied to 0, flag_clr is ignored, and no flag
//                 registers exist.
//
// Ports:
//   clk        in   1            rising-edge clock
//   rst_n      in   1            asynchronous active-low reset
//   in_valid   in   1            input beat offered
//   in_ready   out  1            input beat accepted this cycle
//   in_op      in   2            00 add, 01 subtract, 10 load, 11 clear
//   in_data    in   LANES*WIDTH  operand, lane i at [i*WIDTH +: WIDTH]
//   out_valid  out  1            out_data holds a result not yet taken
//   out_ready  in   1            consumer takes the result this cycle
//   out_data   out  LANES*WIDTH  accumulator values, same packing as in_data
//   sat_flags  out  LANES        sticky per-lane saturation flags
//   flag_clr   in   1            clear sat_flags
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holds valid and its payload until that transfer happens.
// in_ready = !out_valid || out_ready. The slot refills in the same cycle it
// drains, so a beat can transfer every clock with no bubble.
// -----------------------------------------------------------------------------
module sat_accumulator #(
  parameter int WIDTH = 16,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       sat_flags,
  input  logic                   flag_clr
);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;

  localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  // Result-slot state. out_valid is this state, so it doubles as the debug view.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_in_fire;
  logic             w_out_fire;
  logic [LANES-1:0] w_sat_evt;

  assign out_valid  = (r_state == ST_FULL);
  assign in_ready   = !out_valid || out_ready;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_in_fire) w_state_nxt = ST_FULL;
      // Stays full when a new beat arrives in the same cycle the old result drains.
      ST_FULL:  if (w_out_fire && !w_in_fire) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // Per-lane datapath.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_d;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;
    logic [WIDTH-1:0] w_acc_nxt;
    logic             w_sat;

    assign w_d = in_data[gi*WIDTH +: WIDTH];

    // Both operands are sign-extended by one bit, so the result cannot wrap.
    always_comb begin
      if (in_op == OP_SUB) begin
        w_sum = {r_acc[WIDTH-1], r_acc} - {w_d[WIDTH-1], w_d};
      end else begin
        w_sum = {r_acc[WIDTH-1], r_acc} + {w_d[WIDTH-1], w_d};
      end
    end

    // The result is out of range when the two top bits disagree. The top bit
    // gives the true sign, and that sign selects which limit to clamp to.
    assign w_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];

    always_comb begin
      w_acc_nxt = r_acc;
      w_sat     = 1'b0;
      case (in_op)
        OP_ADD, OP_SUB: begin
          if (w_ovf) begin
            w_acc_nxt = w_sum[WIDTH] ? MIN_VAL : MAX_VAL;
            w_sat     = 1'b1;
          end else begin
            w_acc_nxt = w_sum[WIDTH-1:0];
          end
        end
        OP_LOAD: w_acc_nxt = w_d;
        default: w_acc_nxt = '0;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_acc <= '0;
      end else if (w_in_fire) begin
        r_acc <= w_acc_nxt;
      end
    end

    assign out_data[gi*WIDTH +: WIDTH] = r_acc;
    assign w_sat_evt[gi]               = w_sat && w_in_fire;
  end

`ifdef SAT_ACCUMULATOR_STICKY_FLAGS_EN
  logic [LANES-1:0] r_sat_flags;

  // A new saturation event wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_flags <= '0;
    end else begin
      r_sat_flags <= w_sat_evt | (flag_clr ? '0 : r_sat_flags);
    end
  end

  assign sat_flags = r_sat_flags;
`else
  logic w_unused;

  assign w_unused  = flag_clr ^ (^w_sat_evt);
  assign sat_flags = '0;
`endif

endmodule
